// File: rtl/pulse_event_arbiter.sv
// pulse_event_arbiter
// Shares one registered valid/ready event channel between NUM_REQ pulse
// sources. Each source has a saturating pending counter so bursts are held
// while the channel is busy; a round-robin scheduler picks the next source
// whenever the output slot is free.
module pulse_event_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req_pulse,
  output logic                     out_valid,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_ready,
  output logic [NUM_REQ*CNT_W-1:0] pending_cnt,
  output logic [NUM_REQ-1:0]       overflow,
  input  logic [NUM_REQ-1:0]       ovf_clr,
  output logic                     busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   cnt [NUM_REQ];
  logic [ID_W-1:0]    last_grant;

  logic               slot_free;
  logic               found;
  logic               load;
  logic [ID_W-1:0]    winner;
  logic [NUM_REQ-1:0] dec_vec;
  logic [NUM_REQ-1:0] drop_vec;
  logic               any_pending;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && cnt[idx] != '0) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Slot is free when empty or being accepted this cycle; load the winner then.
  always_comb begin
    slot_free = !out_valid || out_ready;
    load      = slot_free && enable && found;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec_vec[i]  = load && (winner == ID_W'(i));
      // A pulse into a full counter is lost unless the same cycle drains one.
      drop_vec[i] = req_pulse[i] && !dec_vec[i] && (cnt[i] == CNT_MAX);
    end
  end

  // Flatten counters onto the status port and derive busy.
  always_comb begin
    pending_cnt = '0;
    any_pending = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pending_cnt[i*CNT_W +: CNT_W] = cnt[i];
      any_pending = any_pending | (cnt[i] != '0);
    end
    busy = out_valid || any_pending;
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      out_valid  <= 1'b0;
      out_id     <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (slot_free) begin
      out_valid <= load;
      if (load) begin
        out_id     <= winner;
        last_grant <= winner;
      end
    end
  end

  // Saturating pending counters and sticky overflow flags.
  always_ff @(posedge clk) begin
    // NOTE: the counter array is a handful of flops, not RAM, so it is reset
    // along with everything else; a reset discards all pending events.
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_pulse[i] && !dec_vec[i]) begin
          if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
        end else if (!req_pulse[i] && dec_vec[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
        // Set beats clear when both land in the same cycle.
        if (drop_vec[i])     overflow[i] <= 1'b1;
        else if (ovf_clr[i]) overflow[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed bench for pulse_event_arbiter: inputs change 1 ns after the rising
// edge and outputs are sampled at the same point, so each tick() observes the
// state produced by exactly one edge.
module tb_pulse_event_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     enable;
  logic [NUM_REQ-1:0]       req_pulse;
  logic                     out_valid;
  logic [ID_W-1:0]          out_id;
  logic                     out_ready;
  logic [NUM_REQ*CNT_W-1:0] pending_cnt;
  logic [NUM_REQ-1:0]       overflow;
  logic [NUM_REQ-1:0]       ovf_clr;
  logic                     busy;

  int checks   = 0;
  int failures = 0;

  pulse_event_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .req_pulse  (req_pulse),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .pending_cnt(pending_cnt),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_of(input int i);
    return int'(pending_cnt[i*CNT_W +: CNT_W]);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Drive pattern p for n consecutive cycles, then return to idle.
  task automatic pulse(input logic [NUM_REQ-1:0] p, input int n);
    for (int k = 0; k < n; k++) begin
      req_pulse = p;
      tick();
    end
    req_pulse = '0;
  endtask

  initial begin
    int hs;
    rst       = 1'b1;
    enable    = 1'b1;
    req_pulse = '0;
    out_ready = 1'b1;
    ovf_clr   = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid", out_valid, 0);
    check("rst_id", out_id, 0);
    check("rst_cnt", int'(pending_cnt), 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);

    // Single event on requester 2: counter, then slot, then idle
    tick(); tick();
    pulse(4'b0100, 1);
    check("single_cnt1", cnt_of(2), 1);
    check("single_notyet", out_valid, 0);
    check("single_busy", busy, 1);
    tick();
    check("single_valid", out_valid, 1);
    check("single_id", out_id, 2);
    check("single_cnt0", cnt_of(2), 0);
    tick();
    check("single_one_cycle", out_valid, 0);
    check("single_busy_low", busy, 0);

    // Round robin: two events per requester preloaded with enable low
    do_reset();
    enable = 1'b0;
    pulse(4'b1111, 2);
    check("rr_preload", int'(pending_cnt), 12'o2222);
    check("rr_hold_off", out_valid, 0);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rr_valid%0d", k), out_valid, 1);
      check($sformatf("rr_id%0d", k), out_id, k % 4);
    end
    tick();
    check("rr_done", out_valid, 0);

    // Backpressure: id 1 holds for 10 cycles, then id 3 right after accept
    do_reset();
    out_ready = 1'b0;
    pulse(4'b1010, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("bp_valid%0d", k), out_valid, 1);
      check($sformatf("bp_id%0d", k), out_id, 1);
    end
    check("bp_cnt3", cnt_of(3), 1);
    out_ready = 1'b1;
    tick();
    check("bp_next_valid", out_valid, 1);
    check("bp_next_id", out_id, 3);
    tick();
    check("bp_idle", out_valid, 0);

    // Saturation: 9 pulses into a 7-deep counter
    do_reset();
    enable    = 1'b0;
    out_ready = 1'b0;
    pulse(4'b0001, 9);
    check("sat_cnt", cnt_of(0), 7);
    check("sat_ovf", overflow, 4'b0001);
    enable    = 1'b1;
    out_ready = 1'b1;
    hs = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid && out_id == 0) hs++;
    end
    check("sat_handshakes", hs, 7);
    check("sat_ovf_sticky", overflow, 4'b0001);
    ovf_clr = 4'b0001;
    tick();
    ovf_clr = '0;
    check("sat_ovf_clr", overflow, 0);

    // Set and clear of overflow in the same cycle: set wins
    do_reset();
    enable = 1'b0;
    pulse(4'b0001, 7);
    check("setwin_pre", overflow, 0);
    ovf_clr = 4'b0001;
    pulse(4'b0001, 1);
    ovf_clr = '0;
    check("setwin_ovf", overflow, 4'b0001);
    check("setwin_cnt", cnt_of(0), 7);

    // Increment and decrement together at max: count holds, no overflow
    do_reset();
    enable    = 1'b0;
    out_ready = 1'b1;
    pulse(4'b0010, 7);
    check("incdec_pre", cnt_of(1), 7);
    enable = 1'b1;
    pulse(4'b0010, 1);
    check("incdec_cnt", cnt_of(1), 7);
    check("incdec_ovf", overflow, 0);
    check("incdec_valid", out_valid, 1);
    check("incdec_id", out_id, 1);

    // Reset mid-operation with counters [3,2,0,5] and an event presented
    do_reset();
    enable    = 1'b0;
    out_ready = 1'b0;
    pulse(4'b1011, 2);
    pulse(4'b1001, 2);
    pulse(4'b1000, 1);
    enable = 1'b1;
    tick();
    check("mid_valid", out_valid, 1);
    check("mid_id", out_id, 0);
    check("mid_cnt", int'(pending_cnt), 12'o5023);
    do_reset();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_cnt", int'(pending_cnt), 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_busy", busy, 0);
    out_ready = 1'b1;
    pulse(4'b1000, 1);
    check("mid_after_cnt", cnt_of(3), 1);
    tick();
    check("mid_after_valid", out_valid, 1);
    check("mid_after_id", out_id, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
